wb_stage_buf: RTL

Parametrised writeback stage with a 2-entry result buffer. It sits between the MEM stage and the register-file write port. It accepts MEM results over a valid/ready handshake and selects the write-back source (ALU, load, PC+4, CSR). It aligns and sign- or zero-extends load data, suppresses x0 writes, flags misaligned loads, and counts retired instructions.

---
 rtl/wb_stage_buf.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_stage_buf.sv
// Writeback stage: a 2-entry in-order result buffer between MEM and the register-file write port.
// Results are formatted and alignment-checked when they are accepted, then stored.
module wb_stage_buf #(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned RADDR_W = 5,
  parameter  int unsigned RET_W   = 64,
  localparam int unsigned LANE_W  = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hazard_stall,
  input  logic               hazard_flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_alu,
  input  logic [XLEN-1:0]    in_rdata,
  input  logic [XLEN-1:0]    in_csr,
  input  logic [1:0]         in_src_sel,
  input  logic [1:0]         in_size,
  input  logic               in_unsigned,
  input  logic [LANE_W-1:0]  in_addr_lo,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_regwrite,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    wb_pc,
  output logic               wb_misaligned,
  output logic [RET_W-1:0]   instret
);

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rd;
    logic               regwrite;
    logic               misaligned;
  } entry_t;

  entry_t           e0, e1, new_e;
  logic [1:0]       count;
  logic [RET_W-1:0] instret_q;
  logic             enq, deq;

  logic [63:0]      raw64, shifted, ext;
  logic             sx, load_mis;

  assign in_ready = (count < 2'd2);
  assign wb_valid = (count != 2'd0);
  assign enq      = in_valid & in_ready & ~hazard_stall & ~hazard_flush;
  assign deq      = wb_valid & wb_ready & ~hazard_stall & ~hazard_flush;

  // Loads are extracted in a 64-bit frame so one path serves both XLEN=32 and XLEN=64.
  always_comb begin
    raw64    = 64'(in_rdata);
    shifted  = raw64 >> {in_addr_lo, 3'b000};
    sx       = 1'b0;
    ext      = '0;
    load_mis = 1'b0;
    unique case (in_size)
      2'b00: begin
        sx  = ~in_unsigned & shifted[7];
        ext = {{56{sx}}, shifted[7:0]};
      end
      2'b01: begin
        sx       = ~in_unsigned & shifted[15];
        ext      = {{48{sx}}, shifted[15:0]};
        load_mis = in_addr_lo[0];
      end
      2'b10: begin
        sx       = ~in_unsigned & shifted[31];
        ext      = {{32{sx}}, shifted[31:0]};
        load_mis = |in_addr_lo[1:0];
      end
      default: begin
        ext      = shifted;
        load_mis = (XLEN == 32) ? 1'b1 : |in_addr_lo;
      end
    endcase

    new_e            = '0;
    new_e.pc         = in_pc;
    new_e.rd         = in_rd;
    new_e.regwrite   = in_regwrite;
    unique case (in_src_sel)
      2'b00: new_e.data = in_alu;
      2'b01: begin
        new_e.misaligned = load_mis;
        new_e.data       = load_mis ? '0 : ext[XLEN-1:0];
      end
      2'b10: new_e.data = in_pc + XLEN'(4);
      default: new_e.data = in_csr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      e0        <= '0;
      e1        <= '0;
      instret_q <= '0;
    end else if (hazard_flush) begin
      count <= '0;
    end else begin
      if (deq) instret_q <= instret_q + RET_W'(1);
      unique case ({enq, deq})
        2'b10: begin
          if (count == 2'd0) e0 <= new_e;
          else               e1 <= new_e;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) e0 <= new_e;
          else begin
            e0 <= e1;
            e1 <= new_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_we         = wb_valid & e0.regwrite & (e0.rd != '0) & ~e0.misaligned;
  assign wb_rd         = wb_valid ? e0.rd : '0;
  assign wb_data       = wb_valid ? e0.data : '0;
  assign wb_pc         = wb_valid ? e0.pc : '0;
  assign wb_misaligned = wb_valid & e0.misaligned;
  assign instret       = instret_q;

endmodule
